// File: rtl/io_block_pkg.sv
// io_block_pkg
//   Shared definitions for the fabric IO block: per-pad config field layout
//   (as functions of the track counts), OE mode encodings and the per-pad
//   config struct for the default geometry.
//   Per-pad config word, LSB first:
//     [WT-1:0] out_sel | [2WT-1:WT] in_drv | [2WT+1:2WT] oe_mode
//     [2WT+2] reg_out  | [2WT+3] reg_in
package io_block_pkg;

  localparam int DEF_WS   = 6;
  localparam int DEF_WD   = 3;
  localparam int DEF_WG   = 3;
  localparam int DEF_NPAD = 4;

  localparam logic [1:0] OE_OFF = 2'b00;
  localparam logic [1:0] OE_ON  = 2'b01;
  localparam logic [1:0] OE_G0  = 2'b10;
  localparam logic [1:0] OE_NG0 = 2'b11;

  function automatic int calc_wt(input int ws, input int wd, input int wg);
    return ws + wd + wg;
  endfunction

  function automatic int calc_pcw(input int ws, input int wd, input int wg);
    return 2 * calc_wt(ws, wd, wg) + 4;
  endfunction

  // out_sel sits at offset 0 of the per-pad word
  function automatic int off_in_drv(input int wt);
    return wt;
  endfunction

  function automatic int off_oe(input int wt);
    return 2 * wt;
  endfunction

  function automatic int off_reg_out(input int wt);
    return 2 * wt + 2;
  endfunction

  function automatic int off_reg_in(input int wt);
    return 2 * wt + 3;
  endfunction

  localparam int DEF_WT  = calc_wt(DEF_WS, DEF_WD, DEF_WG);
  localparam int DEF_PCW = calc_pcw(DEF_WS, DEF_WD, DEF_WG);

  // Field order mirrors the bit layout above (first member = MSB)
  typedef struct packed {
    logic              reg_in;
    logic              reg_out;
    logic [1:0]        oe_mode;
    logic [DEF_WT-1:0] in_drv;
    logic [DEF_WT-1:0] out_sel;
  } pad_cfg_t;

endpackage

// File: rtl/io_pad_cell.sv
// io_pad_cell
//   One bidirectional pad slice: outbound track select (OR of selected
//   tracks), optional output register, OE decode, inbound path with optional
//   input register.
//   Build option: IO_SYNC_EN adds a 2-flop synchronizer on pad_in ahead of
//   the reg_in/bypass mux.
// Ports
//   clk, rst_n   fabric clock, async active-low reset
//   cfg_valid    active config has been loaded; gates OE
//   trk          track vector {global, double, single}
//   out_sel/oe_mode/reg_out/reg_in   this pad's active config fields
//   g0           global[0], OE source for modes 10/11
//   pad_in       from pad cell
//   pad_out/pad_oe  to pad cell
//   i_p          inbound value offered to the track-drive mux
module io_pad_cell
  import io_block_pkg::*;
#(
  parameter int WT = DEF_WT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  input  logic [WT-1:0] trk,
  input  logic [WT-1:0] out_sel,
  input  logic [1:0]    oe_mode,
  input  logic          reg_out,
  input  logic          reg_in,
  input  logic          g0,
  input  logic          pad_in,
  output logic          pad_out,
  output logic          pad_oe,
  output logic          i_p
);

  logic pin;
  logic o_p;
  logic out_q;
  logic in_q;
  logic oe_dec;

`ifdef IO_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], pad_in};
  end

  assign pin = sync_q[1];
`else
  assign pin = pad_in;
`endif

  // Several selected tracks simply OR together
  assign o_p = |(trk & out_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
      in_q  <= 1'b0;
    end else begin
      out_q <= o_p;
      in_q  <= pin;
    end
  end

  assign pad_out = reg_out ? out_q : o_p;
  assign i_p     = reg_in  ? in_q  : pin;

  always_comb begin
    oe_dec = 1'b0;
    case (oe_mode)
      OE_OFF:  oe_dec = 1'b0;
      OE_ON:   oe_dec = 1'b1;
      OE_G0:   oe_dec = g0;
      default: oe_dec = ~g0;
    endcase
  end

  // OE stays combinational so global[0] can gate pads within the cycle
  assign pad_oe = cfg_valid & oe_dec;

endmodule

// File: rtl/io_block_cfg.sv
// io_block_cfg
//   Fabric IO block at the array edge. A serial shadow chain is shifted in
//   and copied to the active config on cfg_load; the active config drives
//   NPAD pad cells and the priority mux that drives tracks from pads.
//   Build option: IO_SYNC_EN (see io_pad_cell) adds input synchronizers.
// Ports
//   clk, rst_n               fabric clock, async active-low reset
//   single/double/global_trk routing tracks (inout); the global bundle is
//                            named global_trk since 'global' is reserved
//   pad_in/pad_out/pad_oe    pad cell interface, pad_oe 1 = drive
//   cfg_en, cfg_in           shift enable and serial data for the shadow
//   cfg_load                 copy shadow to active, marks config valid
//   cfg_out                  shadow[0], for chaining blocks
module io_block_cfg
  import io_block_pkg::*;
#(
  parameter int WS   = DEF_WS,
  parameter int WD   = DEF_WD,
  parameter int WG   = DEF_WG,
  parameter int NPAD = DEF_NPAD
) (
  input  logic            clk,
  input  logic            rst_n,
  inout  wire  [WS-1:0]   single,
  inout  wire  [WD-1:0]   double,
  inout  wire  [WG-1:0]   global_trk,
  input  logic [NPAD-1:0] pad_in,
  output logic [NPAD-1:0] pad_out,
  output logic [NPAD-1:0] pad_oe,
  input  logic            cfg_en,
  input  logic            cfg_in,
  input  logic            cfg_load,
  output logic            cfg_out
);

  localparam int WT     = calc_wt(WS, WD, WG);
  localparam int PCW    = calc_pcw(WS, WD, WG);
  localparam int CFG_W  = NPAD * PCW;
  localparam int OFF_IN = off_in_drv(WT);
  localparam int OFF_OE = off_oe(WT);
  localparam int OFF_RO = off_reg_out(WT);
  localparam int OFF_RI = off_reg_in(WT);

  logic [CFG_W-1:0]          shadow;
  logic [CFG_W-1:0]          active;
  logic                      cfg_valid;
  logic [WT-1:0]             trk;
  logic [NPAD-1:0][WT-1:0]   in_drv;
  logic [NPAD-1:0]           i_p;
  logic [WT-1:0]             trk_en;
  logic [WT-1:0]             trk_val;

  // Shift and load may coincide; load takes the pre-edge shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      active    <= '0;
      cfg_valid <= 1'b0;
    end else begin
      if (cfg_en)   shadow <= {cfg_in, shadow[CFG_W-1:1]};
      if (cfg_load) begin
        active    <= shadow;
        cfg_valid <= 1'b1;
      end
    end
  end

  assign cfg_out = shadow[0];
  assign trk     = {global_trk, double, single};

  for (genvar p = 0; p < NPAD; p++) begin : g_pad
    logic [PCW-1:0] pc;
    assign pc        = active[p*PCW +: PCW];
    assign in_drv[p] = pc[OFF_IN +: WT];

    io_pad_cell #(.WT(WT)) u_pad (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .trk       (trk),
      .out_sel   (pc[WT-1:0]),
      .oe_mode   (pc[OFF_OE +: 2]),
      .reg_out   (pc[OFF_RO]),
      .reg_in    (pc[OFF_RI]),
      .g0        (global_trk[0]),
      .pad_in    (pad_in[p]),
      .pad_out   (pad_out[p]),
      .pad_oe    (pad_oe[p]),
      .i_p       (i_p[p])
    );
  end

  // Walk pads high to low so the lowest-index driver is the last writer
  always_comb begin
    trk_en  = '0;
    trk_val = '0;
    for (int p = NPAD - 1; p >= 0; p--) begin
      for (int t = 0; t < WT; t++) begin
        if (cfg_valid && in_drv[p][t]) begin
          trk_en[t]  = 1'b1;
          trk_val[t] = i_p[p];
        end
      end
    end
  end

  for (genvar t = 0; t < WS; t++) begin : g_drv_s
    assign single[t] = trk_en[t] ? trk_val[t] : 1'bz;
  end
  for (genvar t = 0; t < WD; t++) begin : g_drv_d
    assign double[t] = trk_en[WS+t] ? trk_val[WS+t] : 1'bz;
  end
  for (genvar t = 0; t < WG; t++) begin : g_drv_g
    assign global_trk[t] = trk_en[WS+WD+t] ? trk_val[WS+WD+t] : 1'bz;
  end

endmodule
